// File: rtl/hc85_pkg.sv
// Shared encodings for the serial HC85 compare sequencer.
// Holds cascade/result codes and the FSM state type.
package hc85_pkg;

  localparam logic [2:0] CAS_GT = 3'b100;
  localparam logic [2:0] CAS_EQ = 3'b010;
  localparam logic [2:0] CAS_LT = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hc85_serial_cmp_hc85.sv
// HC85: 4-bit magnitude comparator slice with cascade input.
// Ports: DateA/DateB nibbles, Cas={gt,eq,lt} in, Q={gt,eq,lt} out.
module HC85
  import hc85_pkg::*;
(
  input  logic [3:0] DateA,
  input  logic [3:0] DateB,
  input  logic [2:0] Cas,
  output logic [2:0] Q
);

  // On equal nibbles the cascade decides, including the
  // non-one-hot combinations of the classic part.
  always_comb begin
    Q = CAS_EQ;
    unique case (1'b1)
      (DateA > DateB): Q = CAS_GT;
      (DateA < DateB): Q = CAS_LT;
      default: begin
        if (Cas[1])
          Q = CAS_EQ;
        else if (Cas == 3'b000)
          Q = 3'b101;
        else if (Cas == 3'b101)
          Q = 3'b000;
        else
          Q = Cas;
      end
    endcase
  end

endmodule

// File: rtl/hc85_serial_cmp.sv
// Serial WIDTH-bit compare, one nibble per clock, LSB nibble first.
// Ports: clk, rst_n, req_valid/req_ready, a, b, res_valid/res_ready,
// res={gt,eq,lt}, busy. Macro HC85_SERIAL_CMP_SIGNED_EN: signed mode.
module hc85_serial_cmp
  import hc85_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res,
  output logic             busy
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_cas;
  logic [IW-1:0]    r_idx;

  logic [WIDTH-1:0] w_a_in;
  logic [WIDTH-1:0] w_b_in;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [2:0]       w_q;

`ifdef HC85_SERIAL_CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement onto
  // offset binary, so the unsigned slice orders correctly.
  assign w_a_in = {~a[WIDTH-1], a[WIDTH-2:0]};
  assign w_b_in = {~b[WIDTH-1], b[WIDTH-2:0]};
`else
  assign w_a_in = a;
  assign w_b_in = b;
`endif

  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

  HC85 u_hc85 (
    .DateA (w_a_nib),
    .DateB (w_b_nib),
    .Cas   (r_cas),
    .Q     (w_q)
  );

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_cas     <= CAS_EQ;
      r_idx     <= '0;
      res       <= 3'b000;
      res_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_a     <= w_a_in;
            r_b     <= w_b_in;
            r_cas   <= CAS_EQ;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_cas <= w_q;
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            res       <= w_q;
            res_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc85_serial_cmp.sv
// Scoreboard bench for hc85_serial_cmp, WIDTH=16.
// Driver queues expected results; monitor checks each result.
module tb_hc85_serial_cmp;

  localparam int W = 16;
  localparam int N = W / 4;

  typedef struct {
    logic [2:0] res;
    int         t0;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [2:0]   res;
  logic         busy;

  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  exp_t sb[$];

  hc85_serial_cmp #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: on each rising res_valid pop and compare.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (res_valid && !prev_v) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        check("res", int'(res), int'(e.res));
        check("latency", cyc - e.t0, N);
      end
    end
    prev_v = res_valid;
  end

  task automatic wait_ready(input string nm);
    int k = 0;
    while (!req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check(nm, 0, 1);
  endtask

  task automatic do_cmp(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [2:0] er);
    exp_t e;
    @(negedge clk);
    wait_ready("ready_timeout");
    req_valid = 1'b1;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.res = er;
    e.t0  = cyc;
    sb.push_back(e);
    @(negedge clk);
    wait_ready("done_timeout");
  endtask

  initial begin
    exp_t e;
    int k;
    logic [2:0] signed_exp;

    #2;
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res", int'(res), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_cmp(16'h1234, 16'h1234, 3'b010);
    do_cmp(16'h1235, 16'h1234, 3'b100);
    do_cmp(16'h0FFF, 16'h1000, 3'b001);
    do_cmp(16'h0030, 16'h0300, 3'b001);
    check("res_hold_idle", int'(res), 1);

    // Back-pressure with a second request pending.
    res_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    a = 16'h0005;
    b = 16'h0003;
    @(posedge clk);
    #1;
    e.res = 3'b100;
    e.t0  = cyc;
    sb.push_back(e);
    a = 16'h0001;
    b = 16'h0002;
    k = 0;
    while (!res_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("bp_valid_seen", int'(res_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_res_stable", int'(res), 4);
      check("bp_req_ready", int'(req_ready), 0);
      check("bp_res_valid", int'(res_valid), 1);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_ready", int'(req_ready), 1);
    check("bp_idle_busy", int'(busy), 0);
    check("bp_idle_valid", int'(res_valid), 0);
    @(posedge clk);
    #1;
    check("bp_second_accept", int'(busy), 1);
    e.res = 3'b001;
    e.t0  = cyc;
    sb.push_back(e);
    req_valid = 1'b0;
    @(negedge clk);
    wait_ready("bp_done_timeout");

    // Reset during RUN cycle 2.
    @(negedge clk);
    req_valid = 1'b1;
    a = 16'h1234;
    b = 16'h0000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(res_valid), 0);
    check("mid_rst_ready", int'(req_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_cmp(16'hFFFF, 16'h0000, 3'b100);

`ifdef HC85_SERIAL_CMP_SIGNED_EN
    signed_exp = 3'b001;
`else
    signed_exp = 3'b100;
`endif
    do_cmp(16'h8000, 16'h0001, signed_exp);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
